// File: rtl/prbs8_checker.sv
// prbs8_checker: receive-side checker for the x^8+x^6+x^5+x^4+1 PRBS sequence.
// It synchronises to a serial stream (HUNT -> VERIFY -> LOCK), reports lock status,
// pulses on each mismatch seen while locked and keeps a saturating error count.
// Optional build macro PRBS_INV_EN adds an 'invert' input so the checker can
// follow the inverted generator outputs (effective bit = din ^ invert).
module prbs8_checker #(
    parameter int ERR_W     = 16,
    parameter int LOCK_CNT  = 8,
    parameter int LOSS_ERRS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PRBS_INV_EN
    input  logic             invert,
`endif
    input  logic             din_valid,
    input  logic             din,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_TARGET = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TARGET = 8'(LOSS_ERRS);

    state_t           state_reg, state_next;
    logic [8:1]       hist_reg, hist_next;
    logic [3:0]       fill_reg, fill_next;
    logic [7:0]       ok_reg, ok_next;
    logic [7:0]       slip_reg, slip_next;
    logic             err_pulse_reg, err_pulse_next;
    logic [ERR_W-1:0] err_count_reg, err_count_next;
    logic             locked_reg;

    logic bit_eff;
    logic pred;
    logic mismatch;

`ifdef PRBS_INV_EN
    assign bit_eff = din ^ invert;
`else
    assign bit_eff = din;
`endif

    // Prediction of the next bit from the stored history (hist[1] is the newest bit).
    assign pred     = hist_reg[4] ^ hist_reg[5] ^ hist_reg[6] ^ hist_reg[8];
    assign mismatch = bit_eff ^ pred;

    // Next-state and counter logic; only valid samples advance the checker.
    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_next      = fill_reg;
        ok_next        = ok_reg;
        slip_next      = slip_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;

        if (din_valid) begin
            case (state_reg)
                HUNT: begin
                    hist_next = {hist_reg[7:1], bit_eff};
                    fill_next = fill_reg + 4'd1;
                    if (fill_reg == 4'd7) begin
                        // An all-zero history is the LFSR lock-up pattern: keep hunting.
                        fill_next = 4'd0;
                        if ({hist_reg[7:1], bit_eff} != 8'd0) begin
                            state_next = VERIFY;
                            ok_next    = 8'd0;
                        end
                    end
                end
                VERIFY: begin
                    hist_next = {hist_reg[7:1], bit_eff};
                    if (!mismatch) begin
                        ok_next = ok_reg + 8'd1;
                        if (ok_reg + 8'd1 == LOCK_TARGET) begin
                            state_next = LOCK;
                            slip_next  = 8'd0;
                        end
                    end else begin
                        // Self-synchronising: the bad bit is already in the history.
                        ok_next = 8'd0;
                    end
                end
                LOCK: begin
                    // Feed back the prediction so a channel error cannot poison later predictions.
                    hist_next = {hist_reg[7:1], pred};
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        if (!(&err_count_reg))
                            err_count_next = err_count_reg + ERR_W'(1);
                        slip_next = slip_reg + 8'd1;
                        if (slip_reg + 8'd1 == LOSS_TARGET) begin
                            state_next = HUNT;
                            fill_next  = 4'd0;
                        end
                    end else begin
                        slip_next = 8'd0;
                    end
                end
                default: begin
                    state_next = HUNT;
                    fill_next  = 4'd0;
                end
            endcase
        end

        // Clear wins over an error counted on the same cycle.
        if (err_clr)
            err_count_next = '0;
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            hist_reg      <= '0;
            fill_reg      <= '0;
            ok_reg        <= '0;
            slip_reg      <= '0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
            locked_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_reg      <= fill_next;
            ok_reg        <= ok_next;
            slip_reg      <= slip_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
            locked_reg    <= (state_next == LOCK);
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_prbs8_checker.sv
// tb_prbs8_checker: randomized and directed stimulus for prbs8_checker, checked every
// cycle against a queue-based reference model of the checker's lock/error rules.
// Build with PRBS_INV_EN defined to exercise the inverted-stream scenario too.
module tb_prbs8_checker;

    localparam int ERR_W     = 4;
    localparam int LOCK_CNT  = 8;
    localparam int LOSS_ERRS = 4;
    localparam int CNT_MAX   = (1 << ERR_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             din_valid;
    logic             din;
    logic             err_clr;
    logic             inv;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    prbs8_checker #(
        .ERR_W     (ERR_W),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_ERRS (LOSS_ERRS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PRBS_INV_EN
        .invert    (inv),
`endif
        .din_valid (din_valid),
        .din       (din),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- clean sequence generator ----------------
    logic       gq[$];
    int         g_cnt;
    logic [7:0] g_seed;

    task automatic gen_reset(input logic [7:0] seed);
        gq.delete();
        g_cnt  = 0;
        g_seed = seed;
    endtask

    // x[n] = x[n-4]^x[n-5]^x[n-6]^x[n-8]; the first 8 outputs are the seed bits.
    task automatic gen_next(output logic b);
        if (g_cnt < 8) b = g_seed[g_cnt];
        else           b = gq[4] ^ gq[3] ^ gq[2] ^ gq[0];
        gq.push_back(b);
        if (gq.size() > 8) void'(gq.pop_front());
        g_cnt++;
    endtask

    // ---------------- reference model ----------------
    logic mh[$];      // last 8 history bits, oldest first
    int   m_mode;     // 0 hunting, 1 verifying, 2 locked
    int   m_fill, m_ok, m_slip, m_count;
    int   m_pulse;

    task automatic model_reset();
        mh.delete();
        for (int i = 0; i < 8; i++) mh.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_ok = 0; m_slip = 0; m_count = 0; m_pulse = 0;
    endtask

    task automatic model_push(input logic b);
        mh.push_back(b);
        void'(mh.pop_front());
    endtask

    task automatic model_edge(input logic v, input logic d, input logic clr);
        logic b, p;
        int   ones;
        m_pulse = 0;
        if (v) begin
            b = d ^ inv;
            p = mh[4] ^ mh[3] ^ mh[2] ^ mh[0];
            if (m_mode == 0) begin
                model_push(b);
                m_fill++;
                if (m_fill == 8) begin
                    ones = 0;
                    foreach (mh[i]) ones += int'(mh[i]);
                    m_fill = 0;
                    if (ones != 0) begin m_mode = 1; m_ok = 0; end
                end
            end else if (m_mode == 1) begin
                model_push(b);
                if (b == p) begin
                    m_ok++;
                    if (m_ok == LOCK_CNT) begin m_mode = 2; m_slip = 0; end
                end else begin
                    m_ok = 0;
                end
            end else begin
                model_push(p);
                if (b != p) begin
                    m_pulse = 1;
                    if (m_count < CNT_MAX) m_count++;
                    m_slip++;
                    if (m_slip == LOSS_ERRS) begin m_mode = 0; m_fill = 0; end
                end else begin
                    m_slip = 0;
                end
            end
        end
        if (clr) m_count = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check_value(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One transaction: apply inputs, clock, update model, compare all outputs.
    task automatic step(input logic v, input logic d, input logic clr);
        din_valid = v;
        din       = d;
        err_clr   = clr;
        @(posedge clk);
        #1;
        model_edge(v, d, clr);
        check_value("locked",    int'(locked),    (m_mode == 2) ? 1 : 0);
        check_value("err_pulse", int'(err_pulse), m_pulse);
        check_value("err_count", int'(err_count), m_count);
        check_value("state",     int'(state),     m_mode);
    endtask

    task automatic clean(input int n);
        logic c;
        for (int i = 0; i < n; i++) begin
            gen_next(c);
            step(1'b1, c ^ inv, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = 1'b0;
        err_clr   = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check_value("rst_locked",    int'(locked),    0);
        check_value("rst_err_pulse", int'(err_pulse), 0);
        check_value("rst_err_count", int'(err_count), 0);
        check_value("rst_state",     int'(state),     0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic c;
        logic v, d, clr;
        int   burst;

        inv = 1'b0;
        do_reset();
        gen_reset(8'h01);

        // Clean stream: lock after exactly 8+LOCK_CNT samples, no errors over 1000 bits.
        for (int i = 0; i < 1000; i++) begin
            gen_next(c);
            step(1'b1, c, 1'b0);
            if (i == 14) check_value("lock_early", int'(locked), 0);
            if (i == 15) check_value("lock_at_16", int'(locked), 1);
        end
        check_value("clean_count", int'(err_count), 0);
        $display("clean 1000 bits: locked=%0d err_count=%0d", locked, err_count);

        // Single flipped bit while locked.
        gen_next(c);
        step(1'b1, ~c, 1'b0);
        check_value("flip_pulse",  int'(err_pulse), 1);
        check_value("flip_count",  int'(err_count), 1);
        check_value("flip_locked", int'(locked),    1);
        clean(8);
        check_value("flip_after", int'(err_count), 1);
        $display("single flip: err_count=%0d locked=%0d", err_count, locked);

        // Four consecutive mismatches force loss of lock; then relock.
        for (int i = 0; i < LOSS_ERRS; i++) begin
            gen_next(c);
            step(1'b1, ~c, 1'b0);
        end
        check_value("loss_count",  int'(err_count), 5);
        check_value("loss_locked", int'(locked),    0);
        check_value("loss_state",  int'(state),     0);
        clean(15);
        check_value("relock_early", int'(locked), 0);
        clean(1);
        check_value("relock", int'(locked), 1);
        $display("loss and relock: err_count=%0d locked=%0d", err_count, locked);

        // All-zero stream never leaves HUNT.
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        check_value("zero_state",  int'(state),  0);
        check_value("zero_locked", int'(locked), 0);
        $display("all-zero stream: state=%0d locked=%0d", state, locked);

        // Alternating valid: lock after 16 valid samples; clear beats a same-cycle error.
        do_reset();
        gen_reset(8'h01);
        for (int i = 0; i < 16; i++) begin
            gen_next(c);
            step(1'b1, c, 1'b0);
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        check_value("alt_locked", int'(locked),    1);
        check_value("alt_count",  int'(err_count), 0);
        gen_next(c);
        step(1'b1, ~c, 1'b0);
        clean(3);
        gen_next(c);
        step(1'b1, ~c, 1'b1);
        check_value("clr_pulse", int'(err_pulse), 1);
        check_value("clr_count", int'(err_count), 0);
        $display("err_clr with error: err_count=%0d err_pulse=%0d", err_count, err_pulse);

        // Saturation of the error counter.
        do_reset();
        gen_reset(8'h01);
        clean(16);
        for (int k = 0; k < CNT_MAX + 5; k++) begin
            gen_next(c);
            step(1'b1, ~c, 1'b0);
            clean(3);
        end
        check_value("sat_count",  int'(err_count), CNT_MAX);
        check_value("sat_locked", int'(locked),    1);
        $display("saturation: err_count=%0d", err_count);

        // Randomized stream: gaps, sparse errors, occasional bursts, occasional clears.
        do_reset();
        gen_reset(8'($urandom_range(1, 255)));
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 149) == 0);
            if (v) begin
                gen_next(c);
                if (burst == 0 && $urandom_range(0, 299) == 0) burst = $urandom_range(2, 6);
                if (burst > 0) begin
                    d = ~c;
                    burst--;
                end else begin
                    d = c ^ ($urandom_range(0, 39) == 0);
                end
            end else begin
                d = 1'($urandom_range(0, 1));
            end
            step(v, d, clr);
        end
        $display("random 4000 cycles: state=%0d err_count=%0d", state, err_count);

`ifdef PRBS_INV_EN
        // Inverted stream with invert=1 locks cleanly.
        inv = 1'b1;
        do_reset();
        gen_reset(8'h01);
        clean(200);
        check_value("inv_locked", int'(locked),    1);
        check_value("inv_count",  int'(err_count), 0);
        $display("inverted stream invert=1: locked=%0d", locked);

        // Inverted stream with invert=0 never passes VERIFY.
        inv = 1'b0;
        do_reset();
        gen_reset(8'h01);
        for (int i = 0; i < 200; i++) begin
            gen_next(c);
            step(1'b1, ~c, 1'b0);
        end
        check_value("noinv_locked", int'(locked), 0);
        $display("inverted stream invert=0: locked=%0d", locked);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
